// File: rtl/mopshub_selftest_pkg.sv
// Shared types for the MOPSHUB RX/TX self-test sequencer.
// Pure declarations: no timing, no flow control.
package mopshub_selftest_pkg;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, ENDWAIT, GAP, DONE} selftest_state_t;
  typedef enum logic [1:0] {RX_ONLY, TX_ONLY, RX_TX, LOOP} selftest_mode_t;
  typedef enum logic {PH_RX, PH_TX} phase_t;

  // True when finishing a pass in this phase ends the whole campaign.
  function automatic logic pass_ends_campaign(selftest_mode_t m, phase_t ph);
    if (ph == PH_RX) return (m == RX_ONLY);
    return (m != LOOP);
  endfunction

endpackage

// File: rtl/mopshub_bus_mask_scan.sv
// Finds the lowest enabled bus at or above (inclusive) / strictly above from_id.
// Purely combinational; found=0 when no such bus exists (no wrap-around).
module mopshub_bus_mask_scan #(
  parameter int N_BUSES = 32,
  parameter int BUS_W   = 5
) (
  input  logic [N_BUSES-1:0] mask,
  input  logic [BUS_W-1:0]   from_id,
  input  logic               inclusive,
  output logic [BUS_W-1:0]   next_id,
  output logic               found
);

  always_comb begin
    next_id = '0;
    found   = 1'b0;
    // Walk downwards so the lowest qualifying bus is the last one written.
    for (int i = N_BUSES - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(from_id)) || (inclusive && (i == int'(from_id))))) begin
        next_id = BUS_W'(i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mopshub_selftest_sequencer.sv
// RX/TX self-test sequencer: one request per enabled bus per pass, counts pass/fail/timeout.
// First request one cycle after start; abort returns to IDLE on the next edge from any active state.
module mopshub_selftest_sequencer
  import mopshub_selftest_pkg::*;
#(
  parameter int                   N_BUSES    = 32,
  parameter int                   BUS_W      = $clog2(N_BUSES),
  parameter int                   TIMEOUT_W  = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT    = 16'hFFFF,
  parameter int                   GAP_CYCLES = 120,
  parameter int                   CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [N_BUSES-1:0] bus_mask,
  input  logic               phase_done,
  input  logic               phase_err,
  output logic               test_rx_start,
  output logic               test_tx_start,
  output logic [BUS_W-1:0]   bus_id,
  output logic               endwait_all,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [CNT_W-1:0]   pass_cnt,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic [CNT_W-1:0]   tout_cnt,
  output logic               first_fail_vld,
  output logic [BUS_W-1:0]   first_fail_bus,
  output logic [CNT_W-1:0]   loop_cnt
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  selftest_state_t    state_q, state_d;
  selftest_mode_t     mode_q;
  phase_t             phase_q;
  logic [N_BUSES-1:0] mask_q;
  logic [TIMEOUT_W-1:0] tcnt_q;
  logic [GAP_W-1:0]   gcnt_q;

  logic [N_BUSES-1:0] first_mask;
  logic [BUS_W-1:0]   first_id, next_id;
  logic               first_found, next_found;
  logic               abort_hit, timeout_hit, req_end, gap_last;

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Before the campaign is latched, the first-bus scan must look at the live mask.
  assign first_mask = (state_q == IDLE) ? bus_mask : mask_q;

  mopshub_bus_mask_scan #(.N_BUSES(N_BUSES), .BUS_W(BUS_W)) u_scan_first (
    .mask      (first_mask),
    .from_id   ('0),
    .inclusive (1'b1),
    .next_id   (first_id),
    .found     (first_found)
  );

  mopshub_bus_mask_scan #(.N_BUSES(N_BUSES), .BUS_W(BUS_W)) u_scan_next (
    .mask      (mask_q),
    .from_id   (bus_id),
    .inclusive (1'b0),
    .next_id   (next_id),
    .found     (next_found)
  );

  assign abort_hit   = abort && (state_q != IDLE);
  assign timeout_hit = (tcnt_q == TIMEOUT - 1'b1);
  assign req_end     = phase_done || timeout_hit;
  assign gap_last    = (gcnt_q == GAP_W'(GAP_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = first_found ? REQ : DONE;
      REQ:     state_d = WAIT;
      WAIT: begin
        if (req_end) begin
          if (next_found)                                state_d = REQ;
          else if (pass_ends_campaign(mode_q, phase_q))  state_d = DONE;
          else if (phase_q == PH_RX)                     state_d = ENDWAIT;
          else                                           state_d = REQ;
        end
      end
      ENDWAIT: state_d = GAP;
      GAP:     if (gap_last) state_d = REQ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_hit) state_d = IDLE;
  end

  always_comb begin
    test_rx_start = (state_q == REQ) && (phase_q == PH_RX);
    test_tx_start = (state_q == REQ) && (phase_q == PH_TX);
    endwait_all   = (state_q == ENDWAIT);
    busy          = (state_q == REQ) || (state_q == WAIT) ||
                    (state_q == ENDWAIT) || (state_q == GAP);
    done          = (state_q == DONE) && !abort;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q         <= RX_ONLY;
      phase_q        <= PH_RX;
      mask_q         <= '0;
      bus_id         <= '0;
      tcnt_q         <= '0;
      gcnt_q         <= '0;
      aborted        <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      tout_cnt       <= '0;
      first_fail_vld <= 1'b0;
      first_fail_bus <= '0;
      loop_cnt       <= '0;
    end else begin
      aborted <= 1'b0;
      if (abort_hit) begin
        // Results gathered so far are kept; the in-flight request is simply dropped.
        aborted <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              mode_q         <= selftest_mode_t'(mode);
              mask_q         <= bus_mask;
              phase_q        <= (mode == TX_ONLY) ? PH_TX : PH_RX;
              bus_id         <= first_id;
              pass_cnt       <= '0;
              fail_cnt       <= '0;
              tout_cnt       <= '0;
              first_fail_vld <= 1'b0;
              first_fail_bus <= '0;
              loop_cnt       <= '0;
            end
          end
          REQ: tcnt_q <= '0;
          WAIT: begin
            tcnt_q <= tcnt_q + 1'b1;
            if (phase_done) begin
              if (phase_err) fail_cnt <= sat_inc(fail_cnt);
              else           pass_cnt <= sat_inc(pass_cnt);
            end else if (timeout_hit) begin
              tout_cnt <= sat_inc(tout_cnt);
            end
            if (((phase_done && phase_err) || (!phase_done && timeout_hit)) && !first_fail_vld) begin
              first_fail_vld <= 1'b1;
              first_fail_bus <= bus_id;
            end
            if (req_end) begin
              if (next_found) begin
                bus_id <= next_id;
              end else if ((phase_q == PH_TX) && (mode_q == LOOP)) begin
                loop_cnt <= loop_cnt + 1'b1;
                phase_q  <= PH_RX;
                bus_id   <= first_id;
              end
            end
          end
          ENDWAIT: gcnt_q <= '0;
          GAP: begin
            gcnt_q <= gcnt_q + 1'b1;
            if (gap_last) begin
              phase_q <= PH_TX;
              bus_id  <= first_id;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
